// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter sharing the data-memory port; define DMARB_ROUND_ROBIN_EN for round-robin ties (fixed port-0 priority otherwise)
module dmem_arbiter #(
  parameter int Data_Width    = 32,
  parameter int Address_Width = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Req_0,
  input  logic                     Req_1,
  input  logic                     Lock_0,
  input  logic                     Lock_1,
  input  logic                     Write_Enable_0,
  input  logic                     Write_Enable_1,
  input  logic [Address_Width-1:0] Address_0,
  input  logic [Address_Width-1:0] Address_1,
  input  logic [Data_Width-1:0]    Write_Data_0,
  input  logic [Data_Width-1:0]    Write_Data_1,
  output logic                     Gnt_0,
  output logic                     Gnt_1,
  output logic [Data_Width-1:0]    Read_Data_0,
  output logic [Data_Width-1:0]    Read_Data_1,
  output logic                     Rvalid_0,
  output logic                     Rvalid_1,
  output logic [Address_Width-1:0] Mem_Address,
  output logic [Data_Width-1:0]    Mem_Write_Data,
  output logic                     Mem_Write_Enable,
  input  logic [Data_Width-1:0]    Mem_Read_Data
);
  typedef enum logic [1:0] {IDLE, ACCESS, LOCKED_0, LOCKED_1} state_t;
  state_t                   state_q, state_d;
  logic                     en0, en1, pick0, pick1;
  logic [1:0]               gnt_q, pend_q, rvalid_q;
  logic                     mem_we_q;
  logic [Address_Width-1:0] mem_addr_q;
  logic [Data_Width-1:0]    mem_wdata_q, rdata0_q, rdata1_q;
`ifdef DMARB_ROUND_ROBIN_EN
  logic last_q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) last_q <= 1'b1;
    else if (pick0 | pick1) last_q <= pick1;
  always_comb pick1 = en1 & (~en0 | ~last_q);
`else
  always_comb pick1 = en1 & ~en0;
`endif
  always_comb begin
    en0     = Req_0 & (state_q != LOCKED_1);
    en1     = Req_1 & (state_q != LOCKED_0);
    pick0   = en0 & ~pick1;
    state_d = pick0 ? (Lock_0 ? LOCKED_0 : ACCESS) :
              pick1 ? (Lock_1 ? LOCKED_1 : ACCESS) :
              (state_q == LOCKED_0 || state_q == LOCKED_1) ? state_q : IDLE;
  end
  // pend_q marks a load whose memory cycle ends at the next edge
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      pend_q      <= '0;
      rvalid_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= {pick1, pick0};
      mem_we_q <= pick0 ? Write_Enable_0 : (pick1 & Write_Enable_1);
      if (pick0 | pick1) begin
        mem_addr_q  <= pick1 ? Address_1 : Address_0;
        mem_wdata_q <= pick1 ? Write_Data_1 : Write_Data_0;
      end
      pend_q   <= {pick1 & ~Write_Enable_1, pick0 & ~Write_Enable_0};
      rvalid_q <= pend_q;
      if (pend_q[0]) rdata0_q <= Mem_Read_Data;
      if (pend_q[1]) rdata1_q <= Mem_Read_Data;
    end
  assign Gnt_0            = gnt_q[0];
  assign Gnt_1            = gnt_q[1];
  assign Rvalid_0         = rvalid_q[0];
  assign Rvalid_1         = rvalid_q[1];
  assign Read_Data_0      = rdata0_q;
  assign Read_Data_1      = rdata1_q;
  assign Mem_Address      = mem_addr_q;
  assign Mem_Write_Data   = mem_wdata_q;
  assign Mem_Write_Enable = mem_we_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a small word memory model
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_0 = 1'b0, req_1 = 1'b0, lock_0 = 1'b0, lock_1 = 1'b0, we_0 = 1'b0, we_1 = 1'b0;
  logic [31:0] addr_0 = '0, addr_1 = '0, wdata_0 = '0, wdata_1 = '0;
  logic        gnt_0, gnt_1, rvalid_0, rvalid_1, mem_we;
  logic [31:0] rdata_0, rdata_1, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:15];
  int          n_tests = 0, n_fail = 0;
  dmem_arbiter dut (
    .CLK(clk), .RST(rst_n),
    .Req_0(req_0), .Req_1(req_1), .Lock_0(lock_0), .Lock_1(lock_1),
    .Write_Enable_0(we_0), .Write_Enable_1(we_1),
    .Address_0(addr_0), .Address_1(addr_1),
    .Write_Data_0(wdata_0), .Write_Data_1(wdata_1),
    .Gnt_0(gnt_0), .Gnt_1(gnt_1),
    .Read_Data_0(rdata_0), .Read_Data_1(rdata_1),
    .Rvalid_0(rvalid_0), .Rvalid_1(rvalid_1),
    .Mem_Address(mem_addr), .Mem_Write_Data(mem_wdata), .Mem_Write_Enable(mem_we),
    .Mem_Read_Data(mem_rdata)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [1:0] exp_g;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    req_0 = 1'b1; req_1 = 1'b1; addr_1 = 32'hC;
    tick(); tick();
    check("rst_flags", {27'd0, gnt_1, gnt_0, rvalid_1, rvalid_0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata0", rdata_0, 32'd0);
    check("rst_rdata1", rdata_1, 32'd0);
    rst_n = 1'b1;
    tick();
    check("first_tie", {30'd0, gnt_1, gnt_0}, 32'd1);
    check("first_addr", mem_addr, 32'd0);
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
    check("first_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd1);
    check("first_rdata", rdata_0, 32'h1000_0000);
    check("idle_we", {31'd0, mem_we}, 32'd0);
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 32'd4; wdata_0 = 32'hDEADBEEF;
    tick();
    check("st_gnt", {30'd0, gnt_1, gnt_0}, 32'd1);
    check("st_we", {31'd0, mem_we}, 32'd1);
    check("st_addr", mem_addr, 32'd4);
    check("st_wdata", mem_wdata, 32'hDEADBEEF);
    we_0 = 1'b0;
    tick();
    check("ld_gnt", {30'd0, gnt_1, gnt_0}, 32'd1);
    check("ld_we", {31'd0, mem_we}, 32'd0);
    check("st_no_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd0);
    req_0 = 1'b0;
    tick();
    check("ld_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd1);
    check("ld_rdata", rdata_0, 32'hDEADBEEF);
    tick();
    check("rvalid_pulse", {30'd0, rvalid_1, rvalid_0}, 32'd0);
    check("rdata_hold", rdata_0, 32'hDEADBEEF);
    req_1 = 1'b1; addr_1 = 32'hC;
    tick();
    check("p1_gnt", {30'd0, gnt_1, gnt_0}, 32'd2);
    req_1 = 1'b0;
    tick();
    check("p1_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd2);
    check("p1_rdata", rdata_1, 32'h1000_0003);
    req_0 = 1'b1; addr_0 = 32'h8; req_1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
`ifdef DMARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      check($sformatf("cont_gnt%0d", i), {30'd0, gnt_1, gnt_0}, {30'd0, exp_g});
    end
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
    check("cont_last_rvalid", {30'd0, rvalid_1, rvalid_0}, {30'd0, exp_g});
    tick();
    req_1 = 1'b1; lock_1 = 1'b1; addr_1 = 32'h8;
    tick();
    check("lk_gnt1", {30'd0, gnt_1, gnt_0}, 32'd2);
    req_1 = 1'b0; req_0 = 1'b1; addr_0 = 32'h8;
    tick();
    check("lk_hold_gnt", {30'd0, gnt_1, gnt_0}, 32'd0);
    check("lk_hold_we", {31'd0, mem_we}, 32'd0);
    check("lk_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd2);
    check("lk_rdata", rdata_1, 32'h1000_0002);
    req_1 = 1'b1; we_1 = 1'b1; wdata_1 = 32'h5; lock_1 = 1'b0;
    tick();
    check("unlk_gnt", {30'd0, gnt_1, gnt_0}, 32'd2);
    check("unlk_we", {31'd0, mem_we}, 32'd1);
    check("unlk_wdata", mem_wdata, 32'h5);
    req_1 = 1'b0; we_1 = 1'b0;
    tick();
    check("after_unlk_gnt", {30'd0, gnt_1, gnt_0}, 32'd1);
    req_0 = 1'b0;
    tick();
    check("after_unlk_rdata", rdata_0, 32'h5);
    req_0 = 1'b1; lock_0 = 1'b1; addr_0 = 32'h0;
    tick();
    check("wd_gnt0", {30'd0, gnt_1, gnt_0}, 32'd1);
    req_0 = 1'b0; req_1 = 1'b1; we_1 = 1'b1; addr_1 = 32'h3C; wdata_1 = 32'hBAD;
    tick();
    check("wd_gnt", {30'd0, gnt_1, gnt_0}, 32'd0);
    check("wd_we", {31'd0, mem_we}, 32'd0);
    check("wd_addr", mem_addr, 32'h0);
    req_1 = 1'b0; we_1 = 1'b0;
    tick();
    check("wd_gnt_after", {30'd0, gnt_1, gnt_0}, 32'd0);
    check("wd_mem", mem[15], 32'h1000_000F);
    req_0 = 1'b1; lock_0 = 1'b0;
    tick();
    check("wd_release", {30'd0, gnt_1, gnt_0}, 32'd1);
    req_0 = 1'b0;
    tick(); tick();
    req_1 = 1'b1; addr_1 = 32'h4;
    tick();
    check("mr_gnt1", {30'd0, gnt_1, gnt_0}, 32'd2);
    rst_n = 1'b0; req_1 = 1'b0;
    #1;
    check("mr_gnt_clr", {30'd0, gnt_1, gnt_0}, 32'd0);
    tick();
    check("mr_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'd0);
    check("mr_rdata1", rdata_1, 32'd0);
    rst_n = 1'b1;
    tick();
    check("mr_rvalid_post", {30'd0, rvalid_1, rvalid_0}, 32'd0);
    check("mr_rdata1_post", rdata_1, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
